// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the memory execution path: lsq op,
// CDB writeback packet, memory-stage FSM states and LSU funct3 encodings.
package uarch_pkg;

  localparam int CPU_DATA_BITS = 32;
  localparam int ROB_TAG_W     = 6;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WB,
    DRAIN
  } mau_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [CPU_DATA_BITS-1:0] data;
  } operand_t;

  typedef struct packed {
    logic                 is_valid;
    logic [ROB_TAG_W-1:0] dest_tag;
    operand_t             src_0_a;
    operand_t             src_1_a;
    logic [2:0]           funct3;
    logic                 is_store;
  } instruction_t;

  typedef struct packed {
    logic                     is_valid;
    logic [ROB_TAG_W-1:0]     dest_tag;
    logic [CPU_DATA_BITS-1:0] result;
    logic                     exception;
  } writeback_packet_t;

endpackage

// File: rtl/mem_access_unit_load_align_ext.sv
// Combinational load formatter: selects the byte/half lane of the returned
// word and sign- or zero-extends it. Zero latency, no flow control.
import uarch_pkg::*;

module load_align_ext #(
  parameter int XLEN = CPU_DATA_BITS
) (
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  assign byte_sh = word >> {addr_lo, 3'b000};
  assign half_sh = word >> {addr_lo[1], 4'b0000};

  always_comb begin
    value = word;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      F3_LH:   value = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sh[15:0]};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-entry load/store stage between the lsq and the CDB: one op in flight,
// request held until dcache accepts, writeback held until the CDB grants.
import uarch_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = CPU_DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  instruction_t      execute_pkt,
  output logic              exec_rdy,
  output logic              dcache_req_valid,
  input  logic              dcache_req_ready,
  output logic [ADDR_W-1:0] dcache_req_addr,
  output logic              dcache_req_we,
  output logic [XLEN-1:0]   dcache_req_wdata,
  output logic [3:0]        dcache_req_wmask,
  input  logic              dcache_resp_valid,
  input  logic [XLEN-1:0]   dcache_resp_data,
  input  logic              cache_stall,
  output writeback_packet_t wb_pkt,
  input  logic              wb_grant
);

  mau_state_e           state_q, state_d;
  logic [1:0]           addr_lo_q;
  logic [2:0]           funct3_q;
  logic [ROB_TAG_W-1:0] wb_tag_q;
  logic [XLEN-1:0]      wb_result_q;
  logic                 wb_exc_q;

  logic              accept, req_fire, misaligned;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        st_mask;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_value;

  assign acc_addr         = execute_pkt.src_0_a.data[ADDR_W-1:0];
  assign exec_rdy         = (state_q == IDLE) && !flush;
  assign accept           = execute_pkt.is_valid && exec_rdy;
  assign dcache_req_valid = (state_q == REQ) && !cache_stall;
  assign req_fire         = dcache_req_valid && dcache_req_ready;

  assign wb_pkt.is_valid  = (state_q == WB);
  assign wb_pkt.dest_tag  = wb_tag_q;
  assign wb_pkt.result    = wb_result_q;
  assign wb_pkt.exception = wb_exc_q;

  always_comb begin
    misaligned = 1'b0;
    case (execute_pkt.funct3[1:0])
      2'b01:   misaligned = acc_addr[0];
      2'b10:   misaligned = |acc_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Lanes are replicated so the cache only has to honour wmask.
  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = execute_pkt.src_1_a.data;
    case (execute_pkt.funct3[1:0])
      2'b00: begin
        st_mask  = 4'b0001 << acc_addr[1:0];
        st_wdata = {4{execute_pkt.src_1_a.data[7:0]}};
      end
      2'b01: begin
        st_mask  = 4'b0011 << {acc_addr[1], 1'b0};
        st_wdata = {2{execute_pkt.src_1_a.data[15:0]}};
      end
      default: ;
    endcase
    if (!execute_pkt.is_store) st_mask = 4'b0000;
  end

  load_align_ext #(.XLEN(XLEN)) u_align (
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .word    (dcache_resp_data),
    .value   (ld_value)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = misaligned ? WB : REQ;
      REQ: begin
        // A request that fires alongside a flush is already with the cache.
        if (req_fire)   state_d = dcache_req_we ? (flush ? IDLE : WB) : (flush ? DRAIN : WAIT);
        else if (flush) state_d = IDLE;
      end
      WAIT: begin
        if (dcache_resp_valid) state_d = flush ? IDLE : WB;
        else if (flush)        state_d = DRAIN;
      end
      WB:    if (wb_grant || flush) state_d = IDLE;
      DRAIN: if (dcache_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      addr_lo_q        <= '0;
      funct3_q         <= '0;
      dcache_req_addr  <= '0;
      dcache_req_we    <= 1'b0;
      dcache_req_wdata <= '0;
      dcache_req_wmask <= '0;
      wb_tag_q         <= '0;
      wb_result_q      <= '0;
      wb_exc_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_lo_q        <= acc_addr[1:0];
        funct3_q         <= execute_pkt.funct3;
        dcache_req_addr  <= {acc_addr[ADDR_W-1:2], 2'b00};
        dcache_req_we    <= execute_pkt.is_store;
        dcache_req_wdata <= st_wdata;
        dcache_req_wmask <= st_mask;
        wb_tag_q         <= execute_pkt.dest_tag;
        wb_exc_q         <= misaligned;
        wb_result_q      <= misaligned ? XLEN'(acc_addr) : '0;
      end
      if (state_q == WAIT && dcache_resp_valid && !flush) wb_result_q <= ld_value;
    end
  end

endmodule
